// File: rtl/maple_in_pkg.sv
// rtl/maple_in_pkg.sv - shared state encodings, default pulse counts and helpers for maple_in
package maple_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_TAIL  = 2'd3
  } state_t;

  localparam int DEF_START_PULSES  = 4;
  localparam int DEF_END_PULSES    = 2;
  localparam int DEF_TIMEOUT_TICKS = 255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/maple_in_sync.sv
// rtl/maple_in_sync.sv - 2-FF synchroniser with fall/rise strobes for one Maple bus line
module maple_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic s1, s2, prev;

  // Preset high so an idle bus produces no spurious edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign fall  = prev & ~s2;
  assign rise  = ~prev & s2;

endmodule

// File: rtl/maple_in.sv
// rtl/maple_in.sv - Maple bus receiver: START/data/END decoder feeding the read FIFO
// Define MAPLE_IN_TIMEOUT_EN to abort frames that stall for TIMEOUT_TICKS tick pulses.
module maple_in
  import maple_in_pkg::*;
#(
  parameter int START_PULSES  = DEF_START_PULSES,
  parameter int END_PULSES    = DEF_END_PULSES,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_p1,
  input  logic       in_p5,
  input  logic       enable,
  input  logic       tick,
  input  logic       clear_status,
  input  logic       fifo_ready,
  output logic [7:0] fifo_data,
  output logic       fifo_produce,
  output logic       rx_active,
  output logic       start_seen,
  output logic       end_seen,
  output logic       frame_error,
  output logic       overflow,
  output logic [7:0] byte_count
);

  localparam logic [3:0] START_CNT = 4'(START_PULSES);
  localparam logic [3:0] END_CNT   = 4'(END_PULSES);

  logic p1_lvl, p1_fall, p1_rise;
  logic p5_lvl, p5_fall, p5_rise;

  maple_in_sync u_sync_p1 (.clk(clk), .rst(rst), .din(in_p1), .level(p1_lvl), .fall(p1_fall), .rise(p1_rise));
  maple_in_sync u_sync_p5 (.clk(clk), .rst(rst), .din(in_p5), .level(p5_lvl), .fall(p5_fall), .rise(p5_rise));

  state_t     state;
  logic [3:0] pulse_cnt;
  logic [2:0] bit_cnt;
  logic       phase_b;
  logic [7:0] shreg;
  logic       byte_done;
  logic [7:0] byte_buf;

  logic       both_fall;
  logic       any_edge;
  logic       shift_bit;
  logic [7:0] shift_word;

  // Phase A clocks on pin1 and samples pin5; phase B swaps the roles.
  assign both_fall  = p1_fall & p5_fall;
  assign any_edge   = p1_fall | p1_rise | p5_fall | p5_rise;
  assign shift_bit  = phase_b ? p1_lvl : p5_lvl;
  assign shift_word = {shreg[6:0], shift_bit};
  assign rx_active  = (state != ST_IDLE);

`ifdef MAPLE_IN_TIMEOUT_EN
  logic [7:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = tick ^ (TIMEOUT_TICKS == 0) ^ any_edge;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pulse_cnt    <= '0;
      bit_cnt      <= '0;
      phase_b      <= 1'b0;
      shreg        <= '0;
      byte_done    <= 1'b0;
      byte_buf     <= '0;
      fifo_data    <= '0;
      fifo_produce <= 1'b0;
      start_seen   <= 1'b0;
      end_seen     <= 1'b0;
      frame_error  <= 1'b0;
      overflow     <= 1'b0;
      byte_count   <= '0;
`ifdef MAPLE_IN_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      byte_done    <= 1'b0;
      fifo_produce <= byte_done & fifo_ready;
      if (byte_done && fifo_ready) fifo_data <= byte_buf;

      // Clear first so a coincident flag set below takes priority.
      if (clear_status) begin
        start_seen  <= 1'b0;
        end_seen    <= 1'b0;
        frame_error <= 1'b0;
        overflow    <= 1'b0;
        byte_count  <= '0;
      end
      if (byte_done) begin
        byte_count <= sat_inc8(clear_status ? 8'd0 : byte_count);
        if (!fifo_ready) overflow <= 1'b1;
      end

      if (!enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (p1_fall && p5_lvl) begin
              state     <= ST_START;
              pulse_cnt <= '0;
            end
          end
          ST_START: begin
            if (p1_rise) begin
              if (pulse_cnt == START_CNT) begin
                state      <= ST_DATA;
                start_seen <= 1'b1;
                bit_cnt    <= '0;
                phase_b    <= 1'b0;
              end else begin
                state       <= ST_IDLE;
                frame_error <= 1'b1;
              end
            end else if (p5_fall && !p1_lvl) begin
              pulse_cnt <= sat_inc4(pulse_cnt);
            end
          end
          ST_DATA: begin
            if (both_fall || (phase_b ? p1_fall : (p5_fall && (!p1_lvl || bit_cnt != 3'd0)))) begin
              state       <= ST_IDLE;
              frame_error <= 1'b1;
            end else if (!phase_b && p5_fall) begin
              state     <= ST_TAIL;
              pulse_cnt <= '0;
            end else if (phase_b ? p5_fall : p1_fall) begin
              shreg   <= shift_word;
              bit_cnt <= bit_cnt + 3'd1;
              phase_b <= ~phase_b;
              if (bit_cnt == 3'd7) begin
                byte_done <= 1'b1;
                byte_buf  <= shift_word;
              end
            end
          end
          ST_TAIL: begin
            if (both_fall) begin
              state       <= ST_IDLE;
              frame_error <= 1'b1;
            end else if (p5_rise) begin
              state <= ST_IDLE;
              if (pulse_cnt == END_CNT) end_seen <= 1'b1;
              else frame_error <= 1'b1;
            end else if (p1_fall && !p5_lvl) begin
              pulse_cnt <= sat_inc4(pulse_cnt);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

`ifdef MAPLE_IN_TIMEOUT_EN
      if (!enable || state == ST_IDLE || any_edge) begin
        to_cnt <= '0;
      end else if (tick) begin
        if (to_cnt + 8'd1 == 8'(TIMEOUT_TICKS)) begin
          to_cnt      <= '0;
          state       <= ST_IDLE;
          frame_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_maple_in.sv
// tb/tb_maple_in.sv - randomized self-checking bench for maple_in with a frame-level model
module tb_maple_in;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_p1 = 1'b1;
  logic       in_p5 = 1'b1;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       clear_status = 1'b0;
  logic       fifo_ready = 1'b1;
  logic [7:0] fifo_data;
  logic       fifo_produce;
  logic       rx_active;
  logic       start_seen;
  logic       end_seen;
  logic       frame_error;
  logic       overflow;
  logic [7:0] byte_count;

  maple_in #(.TIMEOUT_TICKS(4)) dut (
    .clk(clk), .rst(rst), .in_p1(in_p1), .in_p5(in_p5), .enable(enable), .tick(tick),
    .clear_status(clear_status), .fifo_ready(fifo_ready), .fifo_data(fifo_data),
    .fifo_produce(fifo_produce), .rx_active(rx_active), .start_seen(start_seen),
    .end_seen(end_seen), .frame_error(frame_error), .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got[$];
  int cyc = 0, drv_cyc = 0, checks = 0, errors = 0;

  // Frame-level model state: sticky flags and byte counter as the spec defines them.
  bit m_start, m_end, m_err, m_ovf;
  int m_cnt;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe checker: every strobe must match the oldest expected byte on exactly its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        checks++;
        if (!(fifo_produce && fifo_data == exp_q[0].data)) begin
          errors++;
          $display("FAIL strobe: produce=%0d data=%02h expected produce=1 data=%02h (cycle %0d)",
                   fifo_produce, fifo_data, exp_q[0].data, cyc);
        end
        void'(exp_q.pop_front());
      end else if (fifo_produce) begin
        checks++;
        errors++;
        $display("FAIL strobe: unexpected produce with data=%02h expected none (cycle %0d)", fifo_data, cyc);
      end
      if (fifo_produce) got.push_back(fifo_data);
    end
  end

  task automatic step(input logic a1, input logic a5);
    @(posedge clk); #1;
    in_p1 = a1;
    in_p5 = a5;
    drv_cyc = cyc;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic model_byte(input logic [7:0] v);
    exp_t e;
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (fifo_ready) begin
      e.data = v;
      e.due  = drv_cyc + 4;
      exp_q.push_back(e);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = v[7-i];
      if (i % 2 == 0) begin
        step(in_p1, b);
        if (!in_p1) step(1'b1, b);
        step(1'b0, b);
      end else begin
        step(1'b0, 1'b1);
        step(b, 1'b1);
        step(b, 1'b0);
      end
    end
    if (n == 8) model_byte(v);
  endtask

  task automatic send_start(input int n);
    step(1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0);
      if (i < n - 1) step(1'b0, 1'b1);
    end
    step(1'b1, in_p5);
  endtask

  task automatic send_end(input int m);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < m; i++) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b1);
  endtask

  task automatic check_flags(input string tag);
    @(negedge clk);
    chk({tag, "_start_seen"}, start_seen, m_start);
    chk({tag, "_end_seen"}, end_seen, m_end);
    chk({tag, "_frame_error"}, frame_error, m_err);
    chk({tag, "_overflow"}, overflow, m_ovf);
    chk({tag, "_byte_count"}, byte_count, m_cnt);
    chk({tag, "_rx_active"}, rx_active, 0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear_status = 1'b1;
    @(posedge clk); #1 clear_status = 1'b0;
    m_start = 0; m_end = 0; m_err = 0; m_ovf = 0; m_cnt = 0;
    check_flags("clear");
  endtask

  // kind: 0 normal END, 1 END after partial byte, 2 enable drop mid-byte, 3 both lines fall.
  task automatic run_frame(input int nst, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nb, input int kind,
                           input int k, input logic [7:0] vp, input int nend);
    logic [7:0] bytes[3];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    send_start(nst);
    if (nst != 4) begin
      m_err = 1'b1;
      step(1'b1, 1'b1);
    end else begin
      m_start = 1'b1;
      for (int i = 0; i < nb; i++) send_bits(bytes[i], 8);
      case (kind)
        0: begin
          send_end(nend);
          if (nend == 2) m_end = 1'b1;
          else m_err = 1'b1;
        end
        1: begin
          send_bits(vp, k);
          send_end(2);
          m_err = 1'b1;
        end
        2: begin
          send_bits(vp, k);
          repeat (2) @(posedge clk);
          #1 enable = 1'b0;
          repeat (3) @(posedge clk);
          step(1'b1, 1'b1);
          @(posedge clk); #1 enable = 1'b1;
        end
        default: begin
          step(1'b1, 1'b0);
          step(1'b1, 1'b1);
          step(1'b0, 1'b0);
          step(1'b1, 1'b1);
          m_err = 1'b1;
        end
      endcase
    end
    repeat (8) @(posedge clk);
    check_flags("frame");
  endtask

  initial begin
    int nst, nb, kind, k, nend;
    m_start = 0; m_end = 0; m_err = 0; m_ovf = 0; m_cnt = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_produce", fifo_produce, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_rx_active", rx_active, 0);
    chk("rst_flags", {start_seen, end_seen, frame_error, overflow}, 0);
    chk("rst_byte_count", byte_count, 0);
    @(posedge clk); #1 rst = 1'b0; enable = 1'b1;
    repeat (3) @(posedge clk);

    // Two good bytes framed by START/END.
    got.delete();
    run_frame(4, 8'hA5, 8'h3C, 8'h00, 2, 0, 0, 8'h00, 2);
    chk("t1_nbytes", got.size(), 2);
    chk("t1_byte0", got.size() > 0 ? got[0] : 8'h00, 8'hA5);
    chk("t1_byte1", got.size() > 1 ? got[1] : 8'h00, 8'h3C);
    chk("t1_seen", {start_seen, end_seen, frame_error}, 3'b110);
    chk("t1_byte_count", byte_count, 2);

    // Short START.
    do_clear();
    got.delete();
    run_frame(3, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 2);
    chk("t2_frame_error", frame_error, 1);
    chk("t2_rx_active", rx_active, 0);
    chk("t2_nbytes", got.size(), 0);

    // Overflow with FIFO full, then clear.
    do_clear();
    fifo_ready = 1'b0;
    run_frame(4, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2);
    chk("t3_overflow", overflow, 1);
    chk("t3_byte_count", byte_count, 1);
    chk("t3_nbytes", got.size(), 0);
    fifo_ready = 1'b1;
    do_clear();
    chk("t3_cleared", {start_seen, end_seen, frame_error, overflow, byte_count}, 0);

    // END inside a partial byte.
    run_frame(4, 8'h00, 8'h00, 8'h00, 0, 1, 6, 8'hB7, 2);
    chk("t4_frame_error", frame_error, 1);
    chk("t4_nbytes", got.size(), 0);

    // Enable dropped mid-byte, then a clean single-byte frame.
    do_clear();
    run_frame(4, 8'h00, 8'h00, 8'h00, 0, 2, 4, 8'hE1, 2);
    chk("t5_no_error", frame_error, 0);
    run_frame(4, 8'h01, 8'h00, 8'h00, 1, 0, 0, 8'h00, 2);
    chk("t5_nbytes", got.size(), 1);
    chk("t5_byte0", got.size() > 0 ? got[0] : 8'hFF, 8'h01);

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      fifo_ready = ($urandom_range(0, 4) != 0);
      nst = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : 4;
      nb = $urandom_range(0, 3);
      k = $urandom_range(0, 9);
      kind = (k < 6) ? 0 : (k < 8) ? 1 : (k == 8) ? 2 : 3;
      k = (kind == 1) ? 2 * $urandom_range(1, 3) : $urandom_range(1, 7);
      nend = ($urandom_range(0, 5) == 0) ? 2 * $urandom_range(0, 1) + 1 : 2;
      run_frame(nst, 8'($urandom), 8'($urandom), 8'($urandom), nb, kind, k, 8'($urandom), nend);
    end
    fifo_ready = 1'b1;

    // Bus frozen right after START with tick running every clock.
    do_clear();
    send_start(4);
    m_start = 1'b1;
    repeat (5) @(posedge clk);
    #1 tick = 1'b1;
    repeat (20) @(posedge clk);
    #1 tick = 1'b0;
    @(negedge clk);
`ifdef MAPLE_IN_TIMEOUT_EN
    chk("t6_frame_error", frame_error, 1);
    chk("t6_rx_active", rx_active, 0);
    m_err = 1'b1;
`else
    chk("t6_rx_active", rx_active, 1);
    chk("t6_frame_error", frame_error, 0);
    #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_disable_idle", rx_active, 0);
`endif
    step(1'b1, 1'b1);
    #1 enable = 1'b1;
    repeat (4) @(posedge clk);
    check_flags("t6");

    repeat (10) @(posedge clk);
    chk("pending_strobes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
